// File: rtl/key_schedule_seq_if.sv
// Round-key stream bundle for key_schedule_seq: start/key in, valid/ready round keys out.
interface key_schedule_seq_if #(
    parameter int Nk = 4
);
    logic              start;
    logic [32*Nk-1:0]  key_in;
    logic              busy;
    logic              rk_valid;
    logic              rk_ready;
    logic [127:0]      rk_out;
    logic [3:0]        rk_index;
    logic              done;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_out, rk_index, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_out, rk_index, done
    );
endinterface

// File: rtl/key_schedule_seq.sv
// Sequential AES key expansion (Nk = 4/6/8): one schedule word per clock, packed into 128-bit round keys.
// Optional macro KEY_SCHED_STORE_EN keeps every accepted round key in a readable array.
module key_schedule_seq #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic               clk,
    input  logic               rst_n,
    key_schedule_seq_if.slave  bus,
    input  logic [3:0]         i_rd_addr,
    output logic [127:0]       o_rd_data
);

    if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
        $error("key_schedule_seq: Nk must be 4, 6 or 8");
    end

    localparam int NW = 4 * (Nr + 1);
    localparam int IW = $clog2(NW + 1);
    localparam int PW = $clog2(Nk);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    // state | meaning
    // IDLE  | wait for start;  GEN | one word per free cycle;  DONE | one-cycle done pulse
    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t          r_state;
    logic [31:0]     r_win [Nk];
    logic [IW-1:0]   r_i;
    logic [PW-1:0]   r_p;
    logic [7:0]      r_rcon;
    logic            r_busy;
    logic            r_done;
    logic            r_rk_valid;
    logic [127:0]    r_rk_out;
    logic [3:0]      r_rk_index;

    logic [31:0]     w_t;
    logic [31:0]     w_base;
    logic [31:0]     w_word;
    logic            w_take;
    logic            w_gen;

    always_comb begin
        w_t    = r_win[Nk-1];
        w_base = r_win[0];
        w_word = w_t ^ w_base;
        // The first Nk words are the key itself, rotated through the window unchanged.
        if (r_i < IW'(Nk)) begin
            w_word = r_win[0];
        end else if (r_p == '0) begin
            w_word = sub_word({w_t[23:0], w_t[31:24]}) ^ {r_rcon, 24'h0} ^ w_base;
        end else if (Nk == 8 && r_p == PW'(4)) begin
            w_word = sub_word(w_t) ^ w_base;
        end
    end

    assign w_take = r_rk_valid & bus.rk_ready;
    assign w_gen  = (r_state == GEN) && (r_i != IW'(NW)) && (!r_rk_valid || bus.rk_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            for (int k = 0; k < Nk; k++) r_win[k] <= '0;
            r_i        <= '0;
            r_p        <= '0;
            r_rcon     <= 8'h01;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rk_out   <= '0;
            r_rk_index <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < Nk; k++) r_win[k] <= bus.key_in[32*(Nk-1-k) +: 32];
                        r_i     <= '0;
                        r_p     <= '0;
                        r_rcon  <= 8'h01;
                        r_busy  <= 1'b1;
                        r_state <= GEN;
                    end
                end
                GEN: begin
                    if (w_take) begin
                        r_rk_valid <= 1'b0;
                        if (r_i == IW'(NW)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    if (w_gen) begin
                        case (r_i[1:0])
                            2'd0:    r_rk_out[127:96] <= w_word;
                            2'd1:    r_rk_out[95:64]  <= w_word;
                            2'd2:    r_rk_out[63:32]  <= w_word;
                            default: r_rk_out[31:0]   <= w_word;
                        endcase
                        if (r_i[1:0] == 2'd3) begin
                            r_rk_valid <= 1'b1;
                            r_rk_index <= 4'(r_i >> 2);
                        end
                        r_i <= r_i + 1'b1;
                        r_p <= (r_p == PW'(Nk - 1)) ? '0 : r_p + 1'b1;
                        if (r_i >= IW'(Nk) && r_p == '0) begin
                            r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                        end
                        for (int k = 0; k < Nk - 1; k++) r_win[k] <= r_win[k+1];
                        r_win[Nk-1] <= w_word;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rk_valid = r_rk_valid;
    assign bus.rk_out   = r_rk_out;
    assign bus.rk_index = r_rk_index;

`ifdef KEY_SCHED_STORE_EN
    // Not reset: contents are only meaningful after a completed schedule.
    logic [127:0] r_store [Nr+1];

    always_ff @(posedge clk) begin
        if (w_take) r_store[r_rk_index] <= r_rk_out;
    end

    assign o_rd_data = (i_rd_addr <= 4'(Nr)) ? r_store[i_rd_addr] : '0;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^i_rd_addr;
    assign o_rd_data   = '0;
`endif

endmodule

// File: doc/key_schedule_seq.md
# key_schedule_seq

Sequential, parametrised AES key schedule generator for AES-128, AES-192 and AES-256, selected by Nk. It produces one 32-bit schedule word per clock from a sliding window of the last Nk words. Words are packed into 128-bit round keys and emitted over a valid/ready stream, with backpressure stalling generation. It sits between the key register and the round datapath and replaces per-round combinational expansion.

## Interface
- Nk, default 4: key length in 32-bit words; legal values are 4, 6 and 8; any other value is an elaboration error.
- Nr, default Nk+6: number of rounds; round keys 0..Nr are emitted.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a schedule; sampled only in IDLE.
- key_in  input  32*Nk  cipher key, word 0 in the MSBs; sampled on the start edge only.
- busy  output  1  high from the start edge until done.
- rk_valid  output  1  rk_out and rk_index are valid.
- rk_ready  input  1  consumer accepts the round key.
- rk_out  output  128  round key; word 4r is in the MSBs.
- rk_index  output  4  round number r, 0..Nr.
- done  output  1  one-cycle pulse after the last round key is accepted.
- rd_addr  input  4  stored round-key address (KEY_SCHED_STORE_EN only).
- rd_data  output  128  stored round key (KEY_SCHED_STORE_EN only).

## Operation
- States:
  - IDLE: start=1 moves to GEN.
  - GEN: one word is produced per cycle while the slot is free.
  - DONE: one cycle that pulses done, then returns to IDLE.
- Start edge: load the window with key_in, clear word counter i=0 and phase p=0, set rcon=8'h01.
- Word i for i<Nk: the word is key word i, taken from the window.
- Word i for i≥Nk, with t = w[i-1] and base w[i-Nk]:
  - p==0: w[i] = SubWord(RotWord(t)) ^ {rcon,24'h0} ^ base; then rcon = xtime(rcon), where 8'h80 maps to 8'h1b.
  - Nk==8 and p==4: w[i] = SubWord(t) ^ base.
  - Otherwise: w[i] = t ^ base.
  - After each word, the window shifts by one.
- p counts 0..Nk-1 and wraps to 0; i counts up to 4*(Nr+1)-1.
- Each word goes into assembly slot i mod 4.
  - When slot 3 fills, rk_valid rises and rk_index = i/4.
  - While rk_valid=1 and rk_ready=0: the window, the counters and rk_out hold.
- Handshake edge (rk_valid & rk_ready): rk_valid clears, and the next word is written into slot 0 on the same edge.
- After the final word (i = 4*(Nr+1)-1) is accepted: go to DONE, pulse done, drop busy, return to IDLE.
- start is ignored while busy. key_in changes after the start edge have no effect.
- Reset values: rk_valid=0, busy=0, done=0, rk_out=0, rk_index=0, state IDLE. Asserting reset mid-schedule aborts it immediately and no partial key is emitted.

## Timing
- Start edge E0; words are written on E1..E4; rk_valid is high after E4 with rk_index=0.
- With rk_ready held high, a round key arrives every 4 cycles (rk_valid is high for 1 cycle in every 4).
- Nk=4: the last key is valid after E44, done is high after E45 and busy is low after E45.
- General case: the last key is valid after edge 4*(Nr+1) plus the number of stall cycles.
- Each stall cycle, where rk_valid=1 and rk_ready=0, delays every later event by exactly one cycle.
- SubWord is four combinational S-box lookups in the same cycle; there is no extra pipeline stage.

## Configuration
- KEY_SCHED_STORE_EN defined:
  - Each accepted round key is also written to an internal (Nr+1)x128 array at rk_index.
  - rd_data = array[rd_addr] combinationally, valid after done. This gives reverse-order access for decryption.
  - Out-of-range rd_addr returns 0. The array is not reset.
- KEY_SCHED_STORE_EN undefined: no array is built and rd_data is tied to 0.

## Test plan
- Nk=4, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1:
  - rk1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - rk10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - done is high after E45.
- Nk=6, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - w6 = fe0c91f7.
  - rk12 = e98ba06f 448c773c 8ecc7204 01002202.
- Nk=8, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - w8 = 9ba35411.
  - rk14 = fe4890d1 e6188d0b 046df344 706c631e. This exercises the p==4 SubWord path.
- Backpressure: Nk=4 with rk_ready low for 7 cycles at rk3.
  - rk_out and rk_index stay stable throughout the stall.
  - rk4 is still correct; done is high after E52.
  - A start pulse while busy changes nothing.
- Reset: drop rst_n at E20 of an Nk=4 run.
  - All outputs are 0 immediately.
  - A restart with a new key gives the correct rk0 after E4.
- KEY_SCHED_STORE_EN, Nk=4: after done, rd_addr=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 and rd_addr=0 gives the key.
